// File: rtl/multicycle_control_unit.sv
// Multicycle sequencer for the RV32 SiMPLE core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath strobes and selects.
module multicycle_control_unit #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       bus_ready,
    output logic       bus_req,
    output logic       bus_write,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       old_pc_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       inst_retired,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);
    // Bus handshake: an access is held (bus_req=1 with bus_write/addr_sel stable)
    // until a cycle with bus_ready=1 completes it; bus_ready is ignored while bus_req=0.

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [15:0] TO_LIMIT = 16'(BUS_TIMEOUT);

    state_t      state_q, state_d;
    logic [15:0] to_cnt;
    logic [1:0]  cause_q, cause_d;
    logic        to_hit;

    // A zero limit disables the timeout entirely.
    assign to_hit     = (TO_LIMIT != 16'd0) && (to_cnt == TO_LIMIT);
    assign state      = state_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_OP_IMM, OP_OP, OP_LUI, OP_AUIPC,
            OP_BRANCH, OP_JAL, OP_JALR, OP_MISC_MEM, OP_SYSTEM: legal_op = 1'b1;
            default:                                            legal_op = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            to_cnt  <= 16'd0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (!bus_req || bus_ready)
                to_cnt <= 16'd0;
            else if (to_cnt != 16'hFFFF)
                to_cnt <= to_cnt + 16'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        bus_req      = 1'b0;
        bus_write    = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        old_pc_write = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = 2'd0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        inst_retired = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                bus_req = 1'b1;
                if (bus_ready) begin
                    ir_write     = 1'b1;
                    old_pc_write = 1'b1;
                    pc_write     = 1'b1;
                    state_d      = S_DECODE;
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (legal_op(opcode)) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = 2'd1;
                        state_d   = S_MEMORY;
                    end
                    OP_OP:     alu_op = 2'd1;
                    OP_OP_IMM: begin
                        alu_src_b = 2'd1;
                        alu_op    = 2'd1;
                    end
                    OP_LUI: begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd1;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd1;
                    end
                    OP_BRANCH: begin
                        alu_op       = 2'd2;
                        pc_write     = branch_taken;
                        pc_src       = 2'd1;
                        inst_retired = 1'b1;
                        state_d      = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd1;
                    end
                    OP_JALR: begin
                        alu_src_b = 2'd1;
                        pc_write  = 1'b1;
                        pc_src    = 2'd2;
                    end
                    default: begin
                        inst_retired = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMORY: begin
                bus_req   = 1'b1;
                addr_sel  = 1'b1;
                bus_write = (opcode == OP_STORE);
                if (bus_ready) begin
                    if (opcode == OP_STORE) begin
                        inst_retired = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (to_hit) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_WRITEBACK: begin
                reg_write    = 1'b1;
                inst_retired = 1'b1;
                if (opcode == OP_LOAD)
                    wb_sel = 2'd1;
                else if (opcode == OP_JAL || opcode == OP_JALR)
                    wb_sel = 2'd2;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for multicycle_control_unit (BUS_TIMEOUT=4).
module tb_multicycle_control_unit;
    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPI = 7'b0010011,
                           OP = 7'b0110011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                           BRANCH = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111,
                           SYSTEM = 7'b1110011, ILLEGAL = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken, bus_ready;
    logic       bus_req, bus_write, addr_sel, ir_write, old_pc_write, pc_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel, trap_cause;
    logic       reg_write, inst_retired, trap;
    logic [2:0] state;

    always #5 clock = ~clock;

    multicycle_control_unit #(.BUS_TIMEOUT(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .bus_ready(bus_ready), .bus_req(bus_req), .bus_write(bus_write),
        .addr_sel(addr_sel), .ir_write(ir_write), .old_pc_write(old_pc_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .wb_sel(wb_sel), .inst_retired(inst_retired), .trap(trap),
        .trap_cause(trap_cause), .state(state)
    );

    typedef struct packed {
        logic       bus_req;
        logic       bus_write;
        logic       addr_sel;
        logic       ir_write;
        logic       old_pc_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       inst_retired;
        logic       trap;
        logic [1:0] trap_cause;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] opc;
        logic       bt;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    outs_t act;
    assign act = {bus_req, bus_write, addr_sel, ir_write, old_pc_write, pc_write,
                  pc_src, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
                  inst_retired, trap, trap_cause, state};

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic outs_t e_zero();
        outs_t o = '0;
        return o;
    endfunction

    function automatic outs_t e_fetch(input logic acc);
        outs_t o = '0;
        o.state = 3'd1; o.bus_req = 1'b1;
        o.ir_write = acc; o.old_pc_write = acc; o.pc_write = acc;
        return o;
    endfunction

    function automatic outs_t e_dec();
        outs_t o = '0;
        o.state = 3'd2;
        return o;
    endfunction

    function automatic outs_t e_ex(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                   input logic pcw, input logic [1:0] pcs, input logic ret);
        outs_t o = '0;
        o.state = 3'd3; o.alu_src_a = a; o.alu_src_b = b; o.alu_op = op;
        o.pc_write = pcw; o.pc_src = pcs; o.inst_retired = ret;
        return o;
    endfunction

    function automatic outs_t e_mem(input logic wr, input logic ret);
        outs_t o = '0;
        o.state = 3'd4; o.bus_req = 1'b1; o.addr_sel = 1'b1;
        o.bus_write = wr; o.inst_retired = ret;
        return o;
    endfunction

    function automatic outs_t e_wb(input logic [1:0] sel);
        outs_t o = '0;
        o.state = 3'd5; o.reg_write = 1'b1; o.inst_retired = 1'b1; o.wb_sel = sel;
        return o;
    endfunction

    function automatic outs_t e_trap(input logic [1:0] cause);
        outs_t o = '0;
        o.state = 3'd7; o.trap = 1'b1; o.trap_cause = cause;
        return o;
    endfunction

    task automatic add(input string n, input logic r, input logic [6:0] op,
                       input logic b, input logic rd, input outs_t e);
        vec_t v;
        v.name = n; v.rst = r; v.opc = op; v.bt = b; v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, compare 1 time unit later, well before the next rising edge.
    task automatic check(input string n, input logic r, input logic [6:0] op,
                         input logic b, input logic rd, input outs_t e);
        @(negedge clock);
        reset = r; opcode = op; branch_taken = b; bus_ready = rd;
        #1;
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     n, act, act.state, e, e.state);
        end
    endtask

    initial begin
        reset = 1'b1; opcode = 7'd0; branch_taken = 1'b0; bus_ready = 1'b0;
        #3 reset = 1'b0;

        add("rst_hold",    0, OP,     0, 1, e_zero());
        add("rst_release", 1, OP,     0, 1, e_zero());
        add("op_fetch",    1, OP,     0, 1, e_fetch(1));
        add("op_decode",   1, OP,     0, 1, e_dec());
        add("op_exec",     1, OP,     0, 1, e_ex(2'd0, 2'd0, 2'd1, 0, 2'd0, 0));
        add("op_wb",       1, OP,     0, 1, e_wb(2'd0));
        add("ld_fetch_w0", 1, LOAD,   0, 0, e_fetch(0));
        add("ld_fetch_w1", 1, LOAD,   0, 0, e_fetch(0));
        add("ld_fetch",    1, LOAD,   0, 1, e_fetch(1));
        add("ld_decode",   1, LOAD,   0, 1, e_dec());
        add("ld_exec",     1, LOAD,   0, 1, e_ex(2'd0, 2'd1, 2'd0, 0, 2'd0, 0));
        add("ld_mem",      1, LOAD,   0, 1, e_mem(0, 0));
        add("ld_wb",       1, LOAD,   0, 1, e_wb(2'd1));
        add("st_fetch",    1, STORE,  0, 1, e_fetch(1));
        add("st_decode",   1, STORE,  0, 1, e_dec());
        add("st_exec",     1, STORE,  0, 1, e_ex(2'd0, 2'd1, 2'd0, 0, 2'd0, 0));
        add("st_mem_wait", 1, STORE,  0, 0, e_mem(1, 0));
        add("st_mem",      1, STORE,  0, 1, e_mem(1, 1));
        add("bt_fetch",    1, BRANCH, 1, 1, e_fetch(1));
        add("bt_decode",   1, BRANCH, 1, 1, e_dec());
        add("bt_exec",     1, BRANCH, 1, 1, e_ex(2'd0, 2'd0, 2'd2, 1, 2'd1, 1));
        add("bn_fetch",    1, BRANCH, 0, 1, e_fetch(1));
        add("bn_decode",   1, BRANCH, 0, 1, e_dec());
        add("bn_exec",     1, BRANCH, 0, 1, e_ex(2'd0, 2'd0, 2'd2, 0, 2'd1, 1));
        add("jal_fetch",   1, JAL,    0, 1, e_fetch(1));
        add("jal_decode",  1, JAL,    0, 1, e_dec());
        add("jal_exec",    1, JAL,    0, 1, e_ex(2'd0, 2'd0, 2'd0, 1, 2'd1, 0));
        add("jal_wb",      1, JAL,    0, 1, e_wb(2'd2));
        add("jalr_fetch",  1, JALR,   0, 1, e_fetch(1));
        add("jalr_decode", 1, JALR,   0, 1, e_dec());
        add("jalr_exec",   1, JALR,   0, 1, e_ex(2'd0, 2'd1, 2'd0, 1, 2'd2, 0));
        add("jalr_wb",     1, JALR,   0, 1, e_wb(2'd2));
        add("lui_fetch",   1, LUI,    0, 1, e_fetch(1));
        add("lui_decode",  1, LUI,    0, 1, e_dec());
        add("lui_exec",    1, LUI,    0, 1, e_ex(2'd2, 2'd1, 2'd0, 0, 2'd0, 0));
        add("lui_wb",      1, LUI,    0, 1, e_wb(2'd0));
        add("auipc_fetch", 1, AUIPC,  0, 1, e_fetch(1));
        add("auipc_dec",   1, AUIPC,  0, 1, e_dec());
        add("auipc_exec",  1, AUIPC,  0, 1, e_ex(2'd1, 2'd1, 2'd0, 0, 2'd0, 0));
        add("auipc_wb",    1, AUIPC,  0, 1, e_wb(2'd0));
        add("sys_fetch",   1, SYSTEM, 0, 1, e_fetch(1));
        add("sys_decode",  1, SYSTEM, 0, 1, e_dec());
        add("sys_exec",    1, SYSTEM, 0, 1, e_ex(2'd0, 2'd0, 2'd0, 0, 2'd0, 1));
        add("opi_fetch",   1, OPI,    0, 1, e_fetch(1));
        add("opi_decode",  1, OPI,    0, 1, e_dec());
        add("opi_exec",    1, OPI,    0, 1, e_ex(2'd0, 2'd1, 2'd1, 0, 2'd0, 0));
        add("opi_wb",      1, OPI,    0, 1, e_wb(2'd0));
        add("st2_fetch",   1, STORE,  0, 1, e_fetch(1));
        add("st2_decode",  1, STORE,  0, 1, e_dec());
        add("st2_exec",    1, STORE,  0, 1, e_ex(2'd0, 2'd1, 2'd0, 0, 2'd0, 0));
        add("st2_mem",     1, STORE,  0, 0, e_mem(1, 0));
        add("st2_async_rst", 0, STORE, 0, 0, e_zero());
        add("st2_rst_hold",  0, STORE, 0, 0, e_zero());
        add("st2_rst_rel",   1, STORE, 0, 0, e_zero());
        add("st2_refetch",   1, STORE, 0, 0, e_fetch(0));
        add("ill_fetch",   1, ILLEGAL, 0, 1, e_fetch(1));
        add("ill_decode",  1, ILLEGAL, 0, 1, e_dec());
        add("ill_trap",    1, ILLEGAL, 0, 1, e_trap(2'd1));

        foreach (vecs[i])
            check(vecs[i].name, vecs[i].rst, vecs[i].opc, vecs[i].bt, vecs[i].rdy, vecs[i].exp);

        // Trap is sticky whatever the bus and branch inputs do.
        for (int i = 0; i < 20; i++)
            check("ill_trap_hold", 1, OP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  e_trap(2'd1));
        check("ill_rst",     0, OP, 0, 0, e_zero());
        check("ill_rst_rel", 1, OP, 0, 0, e_zero());

        // Fetch that never completes: four wait cycles, then the limit cycle traps.
        for (int i = 0; i < 5; i++)
            check("to_fetch_wait", 1, OP, 0, 0, e_fetch(0));
        check("to_trap",      1, OP, 0, 0, e_trap(2'd2));
        check("to_trap_hold", 1, OP, 0, 1, e_trap(2'd2));
        check("to_rst",       0, OP, 0, 0, e_zero());
        check("to_rst_rel",   1, OP, 0, 0, e_zero());

        // Ready arriving in the limit cycle completes the fetch instead of trapping.
        for (int i = 0; i < 4; i++)
            check("lim_fetch_wait", 1, OP, 0, 0, e_fetch(0));
        check("lim_fetch_ok", 1, OP, 0, 1, e_fetch(1));
        check("lim_decode",   1, OP, 0, 1, e_dec());
        check("lim_exec",     1, OP, 0, 1, e_ex(2'd0, 2'd0, 2'd1, 0, 2'd0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
